// File: rtl/l1_threshold_target_if.sv
// Wishbone classic bus bundle between the interconnect thresh_ host port and the threshold target.
// Latency: none (wires only).
// Backpressure: the master holds cyc/stb until ack; the slave never stalls beyond one cycle.
interface l1_threshold_target_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [12:0] adr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic        ack;
    logic [31:0] dat_r;
    logic        err;
    logic        rty;

    modport master (
        output cyc, stb, we, adr, dat_w, sel,
        input  ack, dat_r, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel,
        output ack, dat_r, err, rty
    );
endinterface

// File: rtl/l1_threshold_target.sv
// L1 trigger threshold target: WB shadow bank streamed to beam logic on UPDATE, then one commit strobe.
// Latency: WB ack one cycle after request; stream starts the cycle after the UPDATE ack, one word per ready cycle.
// Backpressure: stream index only advances on thresh_wr_o & thresh_ready_i; optional L1_THRESH_ACTIVE_READBACK_EN adds an active-bank readback.
module l1_threshold_target #(
    parameter int                     NUM_BEAMS    = 48,
    parameter int                     THRESH_BITS  = 18,
    parameter logic [THRESH_BITS-1:0] THRESH_RESET = THRESH_BITS'(4000)
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_ni,
    l1_threshold_target_if.slave         wb,
    output logic [THRESH_BITS-1:0]       thresh_dat_o,
    output logic [$clog2(NUM_BEAMS):0]   thresh_addr_o,
    output logic                         thresh_wr_o,
    input  logic                         thresh_ready_i,
    output logic                         thresh_update_o,
    output logic                         busy_o
);
    localparam int BW = $clog2(NUM_BEAMS);
    localparam int KW = $clog2(2 * NUM_BEAMS);
    localparam logic [KW-1:0] K_NB   = KW'(NUM_BEAMS);
    localparam logic [KW-1:0] K_LAST = KW'(2 * NUM_BEAMS - 1);
    localparam logic [7:0]    NB_W   = 8'(NUM_BEAMS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic                   ack_q;
    logic [31:0]            dat_q;
    logic                   upd_pend_q;
    logic                   lockout_q;
    logic [31:0]            updcnt_q;
    logic [THRESH_BITS-1:0] trig_q [NUM_BEAMS];
    logic [THRESH_BITS-1:0] sub_q  [NUM_BEAMS];
`ifdef L1_THRESH_ACTIVE_READBACK_EN
    logic [THRESH_BITS-1:0] act_trig_q [NUM_BEAMS];
    logic [THRESH_BITS-1:0] act_sub_q  [NUM_BEAMS];
`endif

    // Address decode: adr[12:10] picks the 1 KB region, adr[9:2] the word inside it.
    logic                   req, wr_go, busy_int;
    logic [2:0]             region;
    logic [7:0]             word;
    logic                   beam_ok;
    logic [BW-1:0]          beam;
    logic                   is_ctrl, is_cnt, is_trig, is_sub;
    logic                   shadow_wr, shadow_drop, lockout_clr, start;

    assign req      = wb.cyc & wb.stb & ~ack_q;
    assign wr_go    = req & wb.we;
    assign region   = wb.adr[12:10];
    assign word     = wb.adr[9:2];
    assign beam_ok  = (word < NB_W);
    assign beam     = word[BW-1:0];
    assign is_ctrl  = (region == 3'd0) && (word == 8'd0);
    assign is_cnt   = (region == 3'd0) && (word == 8'd1);
    assign is_trig  = (region == 3'd1) && beam_ok;
    assign is_sub   = (region == 3'd2) && beam_ok;

    // A pending start counts as busy so nothing slips in between the UPDATE ack and STREAM entry.
    assign busy_o      = (state_q != ST_IDLE);
    assign busy_int    = busy_o | upd_pend_q;
    assign shadow_wr   = wr_go & ~busy_int & (is_trig | is_sub);
    assign shadow_drop = wr_go &  busy_int & (is_trig | is_sub);
    assign lockout_clr = wr_go & is_ctrl & wb.dat_w[1];
    assign start       = wr_go & is_ctrl & wb.dat_w[0] & ~busy_int;

    // Stream word k maps to trigger[k] for the first half, subthreshold[k-NUM_BEAMS] after.
    logic                   k_is_sub;
    logic [KW-1:0]          k_off;
    logic [BW-1:0]          k_beam;
    logic [THRESH_BITS-1:0] stream_val;
    logic                   xfer;

    // Split the stream index into bank select and beam number.
    always_comb begin
        k_is_sub = 1'b0;
        k_off    = k_q;
        if (k_q >= K_NB) begin
            k_is_sub = 1'b1;
            k_off    = k_q - K_NB;
        end
    end

    assign k_beam          = k_off[BW-1:0];
    assign stream_val      = k_is_sub ? sub_q[k_beam] : trig_q[k_beam];
    assign thresh_wr_o     = (state_q == ST_STREAM);
    assign thresh_dat_o    = thresh_wr_o ? stream_val : '0;
    assign thresh_addr_o   = thresh_wr_o ? {k_is_sub, k_beam} : '0;
    assign thresh_update_o = (state_q == ST_COMMIT);
    assign xfer            = thresh_wr_o & thresh_ready_i;

    assign wb.ack   = ack_q;
    assign wb.dat_r = dat_q;
    assign wb.err   = 1'b0;
    assign wb.rty   = 1'b0;

    // Byte selects, sub-word address bits and data above THRESH_BITS carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{wb.sel, wb.adr[1:0], wb.dat_w[31:THRESH_BITS], k_off[KW-1:BW]};

    // Read mux, zero-extending thresholds; unmapped and out-of-range words read 0.
    logic [31:0] rd_dat;
    always_comb begin
        rd_dat = 32'd0;
        if (is_ctrl) begin
            rd_dat = {30'd0, lockout_q, busy_o};
        end else if (is_cnt) begin
            rd_dat = updcnt_q;
        end else if (is_trig) begin
            rd_dat = {{(32-THRESH_BITS){1'b0}}, trig_q[beam]};
        end else if (is_sub) begin
            rd_dat = {{(32-THRESH_BITS){1'b0}}, sub_q[beam]};
`ifdef L1_THRESH_ACTIVE_READBACK_EN
        end else if ((region == 3'd3) && beam_ok) begin
            rd_dat = {{(32-THRESH_BITS){1'b0}}, act_trig_q[beam]};
        end else if ((region == 3'd4) && beam_ok) begin
            rd_dat = {{(32-THRESH_BITS){1'b0}}, act_sub_q[beam]};
`endif
        end
    end

    // WB response: single-cycle ack pulse with registered data held until the next ack.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q <= 1'b0;
            dat_q <= 32'd0;
        end else begin
            ack_q <= req;
            if (req) begin
                dat_q <= rd_dat;
            end
        end
    end

    // Control state: start request, sticky LOCKOUT (set beats clear), commit counter.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            upd_pend_q <= 1'b0;
            lockout_q  <= 1'b0;
            updcnt_q   <= 32'd0;
        end else begin
            upd_pend_q <= start;
            if (shadow_drop) begin
                lockout_q <= 1'b1;
            end else if (lockout_clr) begin
                lockout_q <= 1'b0;
            end
            if (state_q == ST_COMMIT) begin
                updcnt_q <= updcnt_q + 32'd1;
            end
        end
    end

    // Shadow bank: software writes land only while idle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            for (int i = 0; i < NUM_BEAMS; i++) begin
                trig_q[i] <= THRESH_RESET;
                sub_q[i]  <= THRESH_RESET;
            end
        end else if (shadow_wr) begin
            if (is_trig) begin
                trig_q[beam] <= wb.dat_w[THRESH_BITS-1:0];
            end else begin
                sub_q[beam] <= wb.dat_w[THRESH_BITS-1:0];
            end
        end
    end

`ifdef L1_THRESH_ACTIVE_READBACK_EN
    // Active bank mirrors what the beam logic has been sent, word by word.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            for (int i = 0; i < NUM_BEAMS; i++) begin
                act_trig_q[i] <= THRESH_RESET;
                act_sub_q[i]  <= THRESH_RESET;
            end
        end else if (xfer) begin
            if (k_is_sub) begin
                act_sub_q[k_beam] <= stream_val;
            end else begin
                act_trig_q[k_beam] <= stream_val;
            end
        end
    end
`endif

    // FSM state and stream index registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    // FSM next state: IDLE -> STREAM (2*NUM_BEAMS words) -> COMMIT (one cycle) -> IDLE.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            ST_IDLE: begin
                if (upd_pend_q) begin
                    state_d = ST_STREAM;
                    k_d     = '0;
                end
            end
            ST_STREAM: begin
                if (xfer) begin
                    if (k_q == K_LAST) begin
                        state_d = ST_COMMIT;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                k_d     = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_l1_threshold_target.sv
// Directed bench for l1_threshold_target: WB register access, full-bank streaming, stalls, lockout, reset abort.
// Latency: checks ack one cycle after request and commit strobe one cycle after the last word.
// Backpressure: drives thresh_ready_i low mid-stream and checks hold-stable data with no skip or duplicate.
module tb_l1_threshold_target;
    localparam int NB = 48;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [17:0] thresh_dat;
    logic [6:0]  thresh_addr;
    logic        thresh_wr;
    logic        thresh_ready = 1'b1;
    logic        thresh_update;
    logic        busy;

    l1_threshold_target_if wb();

    l1_threshold_target dut (
        .wb_clk_i        (clk),
        .wb_rst_ni       (rst_n),
        .wb              (wb),
        .thresh_dat_o    (thresh_dat),
        .thresh_addr_o   (thresh_addr),
        .thresh_wr_o     (thresh_wr),
        .thresh_ready_i  (thresh_ready),
        .thresh_update_o (thresh_update),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference shadow model, updated by hand alongside accepted writes.
    logic [17:0] trig_m [NB];
    logic [17:0] sub_m  [NB];

    // Stream monitor, sampled on the falling edge.
    logic        mon_clr = 1'b0;
    int          cyc_n = 0;
    int          m_xfer = 0, m_upd = 0, m_hold_err = 0, m_stall = 0;
    int          m_last_x = 0, m_upd_cyc = 0;
    logic        prev_stall = 1'b0;
    logic [17:0] p_dat = '0;
    logic [6:0]  p_addr = '0;
    logic [17:0] m_dat  [128];
    logic [6:0]  m_addr [128];

    always @(negedge clk) begin
        cyc_n++;
        if (mon_clr) begin
            m_xfer = 0; m_upd = 0; m_hold_err = 0; m_stall = 0;
            m_last_x = 0; m_upd_cyc = 0; prev_stall = 1'b0;
        end else begin
            if (thresh_wr && prev_stall && (thresh_dat !== p_dat || thresh_addr !== p_addr))
                m_hold_err++;
            if (thresh_wr && thresh_ready) begin
                if (m_xfer < 128) begin
                    m_dat[m_xfer]  = thresh_dat;
                    m_addr[m_xfer] = thresh_addr;
                end
                m_xfer++;
                m_last_x = cyc_n;
            end
            if (thresh_wr && !thresh_ready) m_stall++;
            prev_stall = thresh_wr && !thresh_ready;
            p_dat  = thresh_dat;
            p_addr = thresh_addr;
            if (thresh_update) begin
                m_upd++;
                m_upd_cyc = cyc_n;
            end
        end
    end

    task automatic mon_reset();
        @(posedge clk); #1 mon_clr = 1'b1;
        @(posedge clk); #1 mon_clr = 1'b0;
    endtask

    task automatic wb_xfer(input logic we, input logic [12:0] a, input logic [31:0] d,
                           output logic [31:0] r);
        int lat;
        @(posedge clk); #1;
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = we; wb.adr = a; wb.dat_w = d;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!wb.ack && lat < 10);
        check_val("ack_latency", 32'(lat), 32'd1);
        r = wb.dat_r;
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
    endtask

    task automatic wb_wr(input logic [12:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        wb_xfer(1'b1, a, d, dummy);
    endtask

    task automatic rd_check(input string tag, input logic [12:0] a, input logic [31:0] exp);
        logic [31:0] r;
        wb_xfer(1'b0, a, 32'd0, r);
        check_val(tag, r, exp);
    endtask

    task automatic wait_commit(input string tag);
        int n = 0;
        while (m_upd == 0 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check_val(tag, 32'(m_upd != 0), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_order(input string tag);
        int bad = 0;
        logic [6:0]  ea;
        logic [17:0] ed;
        for (int k = 0; k < 2 * NB; k++) begin
            ea = (k < NB) ? 7'(k) : 7'(64 + k - NB);
            ed = (k < NB) ? trig_m[k] : sub_m[k - NB];
            if (m_addr[k] !== ea || m_dat[k] !== ed) bad++;
        end
        check_val(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < NB; i++) begin
            trig_m[i] = 18'd4000;
            sub_m[i]  = 18'd4000;
        end
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
        wb.adr = '0; wb.dat_w = '0; wb.sel = 4'hF;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ack", 32'(wb.ack), 32'd0);
        check_val("rst_dat", wb.dat_r, 32'd0);
        check_val("rst_wr", 32'(thresh_wr), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_upd", 32'(thresh_update), 32'd0);
        check_val("rst_taddr", 32'(thresh_addr), 32'd0);
        rst_n = 1'b1;

        // Reset values and out-of-range reads.
        rd_check("rd_trig0", 13'h0400, 32'd4000);
        rd_check("rd_bc0", 13'h0BC0, 32'd0);
        rd_check("rd_sub48", 13'h08C0, 32'd0);
        rd_check("rd_trig48", 13'h04C0, 32'd0);
        rd_check("rd_updcnt0", 13'h0004, 32'd0);
        rd_check("rd_active_off", 13'h0C00, 32'd0);

        // Shadow writes with truncation.
        wb_wr(13'h0408, 32'h0000_1234); trig_m[2] = 18'h01234;
        rd_check("rd_trig2", 13'h0408, 32'h1234);
        wb_wr(13'h0808, 32'hFFFF_FFFF); sub_m[2] = 18'h3FFFF;
        rd_check("rd_sub2", 13'h0808, 32'h3FFFF);
        wb_wr(13'h08C0, 32'h0000_0777);
        rd_check("rd_sub48_wr", 13'h08C0, 32'd0);

        // Full stream with ready held high.
        mon_reset();
        thresh_ready = 1'b1;
        wb_wr(13'h0000, 32'd1);
        wait_commit("commit1_wait");
        check_val("s1_words", 32'(m_xfer), 32'd96);
        check_val("s1_w2_addr", 32'(m_addr[2]), 32'h02);
        check_val("s1_w2_dat", 32'(m_dat[2]), 32'h1234);
        check_val("s1_w50_addr", 32'(m_addr[50]), 32'h42);
        check_val("s1_w50_dat", 32'(m_dat[50]), 32'h3FFFF);
        check_val("s1_upd_timing", 32'(m_upd_cyc - m_last_x), 32'd1);
        check_val("s1_upd_count", 32'(m_upd), 32'd1);
        check_order("s1_order");
        check_val("s1_busy", 32'(busy), 32'd0);
        rd_check("s1_updcnt", 13'h0004, 32'd1);
        rd_check("s1_ctrl", 13'h0000, 32'd0);

        // Stream with a 5-cycle ready stall mid-way.
        mon_reset();
        wb_wr(13'h0000, 32'd1);
        n = 0;
        while (m_xfer < 20 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        thresh_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 thresh_ready = 1'b1;
        wait_commit("commit2_wait");
        check_val("s2_words", 32'(m_xfer), 32'd96);
        check_val("s2_stall_seen", 32'(m_stall), 32'd5);
        check_val("s2_hold", 32'(m_hold_err), 32'd0);
        check_order("s2_order");
        rd_check("s2_updcnt", 13'h0004, 32'd2);

        // Writes while busy: dropped shadow, ignored restart, LOCKOUT set then cleared.
        mon_reset();
        thresh_ready = 1'b0;
        wb_wr(13'h0000, 32'd1);
        n = 0;
        while (!busy && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("s3_busy", 32'(busy), 32'd1);
        wb_wr(13'h0400, 32'h0000_0055);
        wb_wr(13'h0000, 32'd1);
        rd_check("s3_ctrl", 13'h0000, 32'd3);
        rd_check("s3_trig0_kept", 13'h0400, 32'd4000);
        #1 thresh_ready = 1'b1;
        wait_commit("commit3_wait");
        repeat (20) @(posedge clk);
        #1;
        check_val("s3_single_commit", 32'(m_upd), 32'd1);
        check_val("s3_words", 32'(m_xfer), 32'd96);
        rd_check("s3_updcnt", 13'h0004, 32'd3);
        rd_check("s3_lockout_sticky", 13'h0000, 32'd2);
        wb_wr(13'h0000, 32'd2);
        rd_check("s3_lockout_clr", 13'h0000, 32'd0);

        // Reset in the middle of a stream.
        wb_wr(13'h0400, 32'd7);
        rd_check("s4_trig0_set", 13'h0400, 32'd7);
        mon_reset();
        wb_wr(13'h0000, 32'd1);
        n = 0;
        while (m_xfer < 30 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        rst_n = 1'b0;
        #1;
        check_val("s4_wr_drop", 32'(thresh_wr), 32'd0);
        check_val("s4_busy_drop", 32'(busy), 32'd0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_val("s4_no_update", 32'(m_upd), 32'd0);
        rd_check("s4_trig0_rst", 13'h0400, 32'd4000);
        rd_check("s4_trig2_rst", 13'h0408, 32'd4000);
        rd_check("s4_updcnt_rst", 13'h0004, 32'd0);
        rd_check("s4_ctrl_rst", 13'h0000, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
